// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - RED/GREEN/YELLOW phase sequencer with packed-BCD countdown
// Night mode forces flashing yellow with both display digits blanked.
module traffic_phase_timer #(
  parameter int RED_TIME    = 28,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       run,
  input  logic       night,
  output logic       light_red,
  output logic       light_yellow,
  output logic       light_green,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       en_tens,
  output logic       en_ones,
  output logic       phase_done
);

  generate
    if (RED_TIME < 1 || RED_TIME > 99) begin : g_bad_red
      $error("traffic_phase_timer: RED_TIME must be 1..99");
    end
    if (GREEN_TIME < 1 || GREEN_TIME > 99) begin : g_bad_green
      $error("traffic_phase_timer: GREEN_TIME must be 1..99");
    end
    if (YELLOW_TIME < 1 || YELLOW_TIME > 99) begin : g_bad_yellow
      $error("traffic_phase_timer: YELLOW_TIME must be 1..99");
    end
  endgenerate

  localparam logic [3:0] RED_TENS    = 4'(RED_TIME / 10);
  localparam logic [3:0] RED_ONES    = 4'(RED_TIME % 10);
  localparam logic [3:0] GREEN_TENS  = 4'(GREEN_TIME / 10);
  localparam logic [3:0] GREEN_ONES  = 4'(GREEN_TIME % 10);
  localparam logic [3:0] YELLOW_TENS = 4'(YELLOW_TIME / 10);
  localparam logic [3:0] YELLOW_ONES = 4'(YELLOW_TIME % 10);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] tens_n, ones_n;
  logic       flash_n;
  logic       done_n;
  logic       red_n, yellow_n, green_n;
  logic       en_tens_n, en_ones_n;

  always_comb begin
    state_n = state;
    tens_n  = bcd_tens;
    ones_n  = bcd_ones;
    flash_n = light_yellow;
    done_n  = 1'b0;

    if (night) begin
      if (state != ST_FLASH) begin
        state_n = ST_FLASH;
        tens_n  = 4'd0;
        ones_n  = 4'd0;
        flash_n = 1'b1;
      end else if (tick) begin
        flash_n = ~light_yellow;
      end
    end else if (state == ST_FLASH) begin
      state_n = ST_RED;
      tens_n  = RED_TENS;
      ones_n  = RED_ONES;
    end else if (tick && run) begin
      if (bcd_tens == 4'd0 && bcd_ones == 4'd1) begin
        done_n = 1'b1;
        case (state)
          ST_RED: begin
            state_n = ST_GREEN;
            tens_n  = GREEN_TENS;
            ones_n  = GREEN_ONES;
          end
          ST_GREEN: begin
            state_n = ST_YELLOW;
            tens_n  = YELLOW_TENS;
            ones_n  = YELLOW_ONES;
          end
          default: begin
            state_n = ST_RED;
            tens_n  = RED_TENS;
            ones_n  = RED_ONES;
          end
        endcase
      end else if (bcd_ones != 4'd0) begin
        ones_n = bcd_ones - 4'd1;
      end else begin
        ones_n = 4'd9;
        tens_n = bcd_tens - 4'd1;
      end
    end

    // Lamps and enables are derived from the next state so they register in step with it.
    red_n     = (state_n == ST_RED);
    green_n   = (state_n == ST_GREEN);
    yellow_n  = (state_n == ST_FLASH) ? flash_n : (state_n == ST_YELLOW);
    en_ones_n = (state_n != ST_FLASH);
    en_tens_n = (state_n != ST_FLASH) && (tens_n != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RED;
      bcd_tens     <= RED_TENS;
      bcd_ones     <= RED_ONES;
      light_red    <= 1'b1;
      light_yellow <= 1'b0;
      light_green  <= 1'b0;
      en_tens      <= (RED_TENS != 4'd0);
      en_ones      <= 1'b1;
      phase_done   <= 1'b0;
    end else begin
      state        <= state_n;
      bcd_tens     <= tens_n;
      bcd_ones     <= ones_n;
      light_red    <= red_n;
      light_yellow <= yellow_n;
      light_green  <= green_n;
      en_tens      <= en_tens_n;
      en_ones      <= en_ones_n;
      phase_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed vector bench for traffic_phase_timer
// Second instance uses YELLOW_TIME=9 to exercise tens blanking over a longer yellow phase.
module tb_traffic_phase_timer;

  logic clk = 1'b0;
  logic rst_n, tick, run, night;

  logic       red, yellow, green, en_t, en_o, pd;
  logic [3:0] tens, ones;
  logic       red9, yellow9, green9, en_t9, en_o9, pd9;
  logic [3:0] tens9, ones9;

  int checks = 0;
  int errors = 0;
  int pd_count = 0;

  always #5 clk = ~clk;

  traffic_phase_timer u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .night(night),
    .light_red(red), .light_yellow(yellow), .light_green(green),
    .bcd_tens(tens), .bcd_ones(ones), .en_tens(en_t), .en_ones(en_o),
    .phase_done(pd)
  );

  traffic_phase_timer #(.YELLOW_TIME(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .night(night),
    .light_red(red9), .light_yellow(yellow9), .light_green(green9),
    .bcd_tens(tens9), .bcd_ones(ones9), .en_tens(en_t9), .en_ones(en_o9),
    .phase_done(pd9)
  );

  always @(negedge clk) if (pd) pd_count++;

  typedef struct {
    logic       tick, run, night;
    int         lamps;
    int         tens, ones;
    logic       en_t, en_o, pd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // lamps encoded {red,yellow,green}: RED=4 YELLOW=2 GREEN=1
  task automatic chk_all(input string name, input int lamps, input int t, input int o,
                         input int et, input int eo, input int p);
    chk({name, " lamps"}, int'({red, yellow, green}), lamps);
    chk({name, " tens"}, int'(tens), t);
    chk({name, " ones"}, int'(ones), o);
    chk({name, " en_tens"}, int'(en_t), et);
    chk({name, " en_ones"}, int'(en_o), eo);
    chk({name, " phase_done"}, int'(pd), p);
  endtask

  task automatic step(input logic t, input logic r, input logic n);
    @(negedge clk);
    tick  = t;
    run   = r;
    night = n;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    run   = 1'b1;
    night = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rem;
    int pd_before;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 4, 2, 8, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4, 2, 8, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4, 2, 7, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4, 2, 7, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4, 2, 7, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4, 2, 6, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 4, 2, 5, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4, 2, 4, 1'b1, 1'b1, 1'b0};

    do_reset();
    #1;
    chk_all("reset", 4, 2, 8, 1, 1, 0);
    pd_count = 0;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].tick, vecs[i].run, vecs[i].night);
      chk_all($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].tens, vecs[i].ones,
              int'(vecs[i].en_t), int'(vecs[i].en_o), int'(vecs[i].pd));
    end

    // RED down to 01, through the 10 -> 09 boundary
    for (rem = 23; rem >= 1; rem--) begin
      step(1'b1, 1'b1, 1'b0);
      chk_all($sformatf("red%0d", rem), 4, rem / 10, rem % 10, (rem >= 10) ? 1 : 0, 1, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk_all("to_green", 1, 2, 5, 1, 1, 1);
    step(1'b0, 1'b1, 1'b0);
    chk_all("green_hold", 1, 2, 5, 1, 1, 0);
    chk("dut9 green lamps", int'({red9, yellow9, green9}), 1);

    for (rem = 24; rem >= 17; rem--) step(1'b1, 1'b1, 1'b0);
    chk_all("green17", 1, 1, 7, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_all($sformatf("frozen%0d", i), 1, 1, 7, 1, 1, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk_all("green16", 1, 1, 6, 1, 1, 0);
    for (rem = 15; rem >= 1; rem--) step(1'b1, 1'b1, 1'b0);
    chk_all("green01", 1, 0, 1, 0, 1, 0);

    step(1'b1, 1'b1, 1'b0);
    chk_all("to_yellow", 2, 0, 3, 0, 1, 1);
    chk("dut9 yellow lamps", int'({red9, yellow9, green9}), 2);
    chk("dut9 yellow ones", int'(ones9), 9);
    chk("dut9 yellow en_tens", int'(en_t9), 0);

    for (int t = 1; t <= 9; t++) begin
      step(1'b1, 1'b1, 1'b0);
      if (t < 3)
        chk_all($sformatf("yel_t%0d", t), 2, 0, 3 - t, 0, 1, 0);
      else if (t == 3)
        chk_all("back_red", 4, 2, 8, 1, 1, 1);
      else
        chk_all($sformatf("red_t%0d", t), 4, (31 - t) / 10, (31 - t) % 10, 1, 1, 0);
      if (t < 9) begin
        chk($sformatf("dut9 t%0d lamps", t), int'({red9, yellow9, green9}), 2);
        chk($sformatf("dut9 t%0d tens", t), int'(tens9), 0);
        chk($sformatf("dut9 t%0d ones", t), int'(ones9), 9 - t);
        chk($sformatf("dut9 t%0d en_tens", t), int'(en_t9), 0);
      end else begin
        chk("dut9 red lamps", int'({red9, yellow9, green9}), 4);
        chk("dut9 red ones", int'(ones9), 8);
        chk("dut9 red pd", int'(pd9), 1);
      end
    end
    chk("phase_done pulses", pd_count, 3);

    // Async reset between edges, mid-GREEN
    repeat (24) step(1'b1, 1'b1, 1'b0);
    chk_all("green23", 1, 2, 3, 1, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4, 2, 8, 1, 1, 0);
    chk("dut9 async_reset lamps", int'({red9, yellow9, green9}), 4);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    chk_all("post_reset_hold", 4, 2, 8, 1, 1, 0);

    // Night mode entered mid-YELLOW with a coincident tick
    repeat (54) step(1'b1, 1'b1, 1'b0);
    chk_all("yellow02", 2, 0, 2, 0, 1, 0);
    pd_before = pd_count;
    step(1'b1, 1'b1, 1'b1);
    chk_all("flash_entry", 2, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    chk_all("flash_t1", 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1);
    chk_all("flash_t2", 2, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    chk_all("flash_hold", 2, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    chk_all("flash_t3", 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    chk_all("flash_t4", 2, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("flash_exit", 4, 2, 8, 1, 1, 0);
    chk("no pulse across flash", pd_count, pd_before);
    step(1'b1, 1'b1, 1'b0);
    chk_all("after_flash_tick", 4, 2, 7, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
Upstream stage of the traffic-light display path. It sequences one approach through its RED, GREEN and YELLOW phases and counts down the remaining seconds of each phase in packed BCD. Its tens and ones digits and their enables feed two 7-segment decoder instances directly. A night input switches the approach to flashing yellow with the display blanked.

Parameters:
RED_TIME, 28, RED phase length in seconds; legal 1..99
GREEN_TIME, 25, GREEN phase length in seconds; legal 1..99
YELLOW_TIME, 3, YELLOW phase length in seconds; legal 1..99

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide 1 Hz enable pulse from the prescaler
run  input  1  1 = count; 0 = freeze the count and phase
night  input  1  1 = flashing-yellow mode
light_red  output  1  red lamp on
light_yellow  output  1  yellow lamp on
light_green  output  1  green lamp on
bcd_tens  output  4  remaining seconds, tens digit, values 0..9
bcd_ones  output  4  remaining seconds, ones digit, values 0..9
en_tens  output  1  tens digit display enable; low = blank
en_ones  output  1  ones digit display enable; low = blank
phase_done  output  1  one-clk pulse when a phase expires

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst_n=0):
  - state=RED, count=RED_TIME (tens=RED_TIME/10, ones=RED_TIME%10).
  - light_red=1, light_yellow=0, light_green=0.
  - phase_done=0, en_ones=1.
  - en_tens=1 if the tens digit is nonzero, else 0.
- States: RED, GREEN, YELLOW, FLASH. Lamps are one-hot per state; in FLASH only light_yellow may be 1.
- Normal sequence is RED -> GREEN -> YELLOW -> RED.
- Count update, on a clk edge with tick=1, run=1, night=0:
  - If count==01: go to the next state, load that state's time constant, and pulse phase_done=1 for that cycle.
  - Otherwise decrement count in BCD:
    - ones!=0: ones-1.
    - ones==0: ones=9, tens-1.
- Displayed value runs from TIME down to 1; 00 is never shown in a normal phase.
- tick=0 or run=0 (with night=0): state and count hold, phase_done=0.
- tick is used only as a clock enable, never as a clock.
- Leading-zero blanking: en_tens=0 whenever tens==0 in a non-FLASH state; en_ones=1 in non-FLASH states.
- Entering FLASH:
  - night=1 at any clk edge in any state moves to FLASH on that edge, regardless of tick or run.
  - Entry sets light_yellow=1, count=00, en_tens=en_ones=0, phase_done=0.
- In FLASH:
  - Each tick=1 toggles light_yellow; run is ignored.
  - phase_done stays 0.
- Leaving FLASH: the first edge with night=0 goes to RED, loads RED_TIME and restores the display enables. No phase_done pulse on this transition.
- Priority, highest first: rst_n, night, tick&&run expiry, tick&&run decrement.
- Reset mid-phase: immediate return to the reset values; no partial-count retention.
- Time constants are split into tens/ones at elaboration (constant divide/modulo); there is no runtime binary-to-BCD logic.
- Parameters outside 1..99 are illegal; the implementation flags them with an elaboration-time error.

Test Plan:
- Reset then release with night=0, run=1 and no tick -> RED, tens=2, ones=8, en_tens=1, en_ones=1, held indefinitely.
- 27 ticks from reset -> count 01; 28th tick -> GREEN, count 25, phase_done high exactly 1 cycle. 10->09 boundary: ones wraps to 9, tens 1->0, en_tens drops to 0.
- Full cycle of 28+25+3 ticks -> RED/GREEN/YELLOW lamps one-hot in order; back to RED 28; exactly 3 phase_done pulses.
- Assert run=0 mid-GREEN at count 17, then 5 ticks -> count stays 17. Release run -> next tick gives 16.
- Assert night mid-YELLOW at count 2, coincident with a tick -> FLASH: en_tens=en_ones=0, light_yellow=1. 4 ticks -> yellow toggles 0,1,0,1. Deassert night -> RED, 28, displays enabled, no phase_done.
- Pulse rst_n low asynchronously mid-GREEN (between clk edges) -> outputs return to RED/28 before the next edge. Sim with YELLOW_TIME=9 -> tens blank through the whole YELLOW phase.
